// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: bus widths, reset vector,
// reset polarity, FSM state encoding and the next-PC select type.
package ifu_pkg;

  localparam int InstBus     = 32;
  localparam int InstAddrBus = 64;

  localparam logic                   RstEnable = 1'b1;
  localparam logic [InstAddrBus-1:0] RESET_PC  = 64'h0000_0000_8000_0000;

  typedef enum logic [2:0] {
    IFU_IDLE = 3'd0,
    IFU_REQ  = 3'd1,
    IFU_WAIT = 3'd2,
    IFU_OUT  = 3'd3,
    IFU_HALT = 3'd4
  } ifu_state_e;

  typedef enum logic [1:0] {
    PC_HOLD     = 2'd0,
    PC_INC      = 2'd1,
    PC_REDIRECT = 2'd2
  } pc_sel_e;

  function automatic logic is_inst_aligned(input logic [InstAddrBus-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/ifu_pc.sv
// Architectural fetch PC register with its next-PC mux (hold / +4 / redirect).
module ifu_pc
  import ifu_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  pc_sel_e                pc_sel,
  input  logic [InstAddrBus-1:0] redirect_pc,
  output logic [InstAddrBus-1:0] pc
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its inputs regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      pc <= RESET_PC;
    end else begin
      unique case (pc_sel)
        PC_INC:      pc <= pc + 64'd4;
        PC_REDIRECT: pc <= redirect_pc;
        default:     pc <= pc;
      endcase
    end
  end

endmodule

// File: rtl/ifu.sv
// Instruction fetch stage: one outstanding 32-bit fetch, response buffered and
// handed to decode with valid/ready; redirects flush and restart at a target.
module ifu
  import ifu_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req_valid_o,
  input  logic                   imem_req_ready_i,
  output logic [InstAddrBus-1:0] imem_req_addr_o,
  input  logic                   imem_rsp_valid_i,
  input  logic [InstBus-1:0]     imem_rsp_data_i,
  output logic [InstBus-1:0]     inst_o_ifu,
  output logic [InstAddrBus-1:0] pc_o_ifu,
  output logic                   valid_o_ifu,
  input  logic                   ready_i_ifu,
  input  logic                   redirect_valid_i,
  input  logic [InstAddrBus-1:0] redirect_pc_i,
  output logic                   fetch_fault_o
);

  ifu_state_e             state_q, state_d;
  logic                   drop_q, drop_d;
  logic                   valid_d, fault_d;
  logic                   capture;
  pc_sel_e                pc_sel;
  logic [InstAddrBus-1:0] pc;
  logic                   redirect_ok, redirect_bad;

  ifu_pc u_pc (
    .clk         (clk),
    .rst         (rst),
    .pc_sel      (pc_sel),
    .redirect_pc (redirect_pc_i),
    .pc          (pc)
  );

  assign redirect_ok  = redirect_valid_i &&  is_inst_aligned(redirect_pc_i);
  assign redirect_bad = redirect_valid_i && !is_inst_aligned(redirect_pc_i);

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    valid_d = valid_o_ifu;
    fault_d = fetch_fault_o;
    capture = 1'b0;
    pc_sel  = PC_HOLD;

    unique case (state_q)
      IFU_IDLE: state_d = IFU_REQ;

      IFU_REQ: begin
        if (redirect_bad) begin
          state_d = IFU_HALT;
          fault_d = 1'b1;
        end else if (redirect_ok) begin
          pc_sel = PC_REDIRECT;
          // An accepted request now targets the old PC; its response is stale.
          if (imem_req_ready_i) begin
            state_d = IFU_WAIT;
            drop_d  = 1'b1;
          end
        end else if (imem_req_ready_i) begin
          state_d = IFU_WAIT;
          drop_d  = 1'b0;
        end
      end

      IFU_WAIT: begin
        if (redirect_bad) begin
          state_d = IFU_HALT;
          fault_d = 1'b1;
        end else if (redirect_ok) begin
          pc_sel = PC_REDIRECT;
          if (imem_rsp_valid_i) begin
            state_d = IFU_REQ;
            drop_d  = 1'b0;
          end else begin
            drop_d  = 1'b1;
          end
        end else if (imem_rsp_valid_i) begin
          drop_d = 1'b0;
          if (drop_q) begin
            state_d = IFU_REQ;
          end else begin
            state_d = IFU_OUT;
            capture = 1'b1;
            valid_d = 1'b1;
          end
        end
      end

      IFU_OUT: begin
        if (redirect_bad) begin
          state_d = IFU_HALT;
          valid_d = 1'b0;
          fault_d = 1'b1;
        end else if (redirect_ok) begin
          // A same-cycle consume is overridden: the target wins over PC+4.
          state_d = IFU_REQ;
          valid_d = 1'b0;
          pc_sel  = PC_REDIRECT;
        end else if (ready_i_ifu) begin
          state_d = IFU_REQ;
          valid_d = 1'b0;
          pc_sel  = PC_INC;
        end
      end

      IFU_HALT: begin
        valid_d = 1'b0;
        fault_d = 1'b1;
      end

      default: state_d = IFU_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state_q       <= IFU_IDLE;
      drop_q        <= 1'b0;
      valid_o_ifu   <= 1'b0;
      fetch_fault_o <= 1'b0;
      inst_o_ifu    <= '0;
      pc_o_ifu      <= '0;
    end else begin
      state_q       <= state_d;
      drop_q        <= drop_d;
      valid_o_ifu   <= valid_d;
      fetch_fault_o <= fault_d;
      if (capture) begin
        inst_o_ifu <= imem_rsp_data_i;
        pc_o_ifu   <= pc;
      end
    end
  end

  assign imem_req_valid_o = (state_q == IFU_REQ);
  assign imem_req_addr_o  = pc;

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: a transaction-level fetch model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [63:0] imem_req_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic [31:0] inst_o_ifu;
  logic [63:0] pc_o_ifu;
  logic        valid_o_ifu;
  logic        ready_i_ifu;
  logic        redirect_valid_i;
  logic [63:0] redirect_pc_i;
  logic        fetch_fault_o;

  int n_tests = 0;
  int n_fail  = 0;

  ifu dut (
    .clk              (clk),
    .rst              (rst),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .inst_o_ifu       (inst_o_ifu),
    .pc_o_ifu         (pc_o_ifu),
    .valid_o_ifu      (valid_o_ifu),
    .ready_i_ifu      (ready_i_ifu),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .fetch_fault_o    (fetch_fault_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Fetch model in terms of transactions: whether a request is being offered,
  // whether one is in flight (and already known stale), and what decode holds.
  typedef struct packed {
    logic        idle;
    logic        issuing;
    logic        inflight;
    logic        stale;
    logic        out;
    logic        halted;
    logic [63:0] pc;
    logic [63:0] out_pc;
    logic [31:0] out_inst;
  } model_t;

  localparam model_t M_RESET = '{idle: 1'b1, issuing: 1'b0, inflight: 1'b0, stale: 1'b0,
                                 out: 1'b0, halted: 1'b0, pc: 64'h8000_0000,
                                 out_pc: 64'h0, out_inst: 32'h0};
  model_t m;

  function automatic model_t model_next(input model_t cur);
    model_t nxt;
    logic   accept, rsp;
    nxt    = cur;
    accept = cur.issuing && imem_req_ready_i;
    rsp    = cur.inflight && imem_rsp_valid_i;
    if (cur.halted) return nxt;
    if (cur.idle) begin
      nxt.idle    = 1'b0;
      nxt.issuing = 1'b1;
      return nxt;
    end
    if (redirect_valid_i) begin
      if (redirect_pc_i[1:0] != 2'b00) begin
        nxt.halted = 1'b1; nxt.issuing = 1'b0; nxt.inflight = 1'b0; nxt.out = 1'b0;
        return nxt;
      end
      nxt.pc  = redirect_pc_i;
      nxt.out = 1'b0;
      if (cur.out || (cur.issuing && !accept)) begin
        nxt.issuing = 1'b1;
      end else if (rsp) begin
        nxt.inflight = 1'b0; nxt.stale = 1'b0; nxt.issuing = 1'b1;
      end else begin
        nxt.issuing = 1'b0; nxt.inflight = 1'b1; nxt.stale = 1'b1;
      end
      return nxt;
    end
    if (accept) begin
      nxt.issuing = 1'b0; nxt.inflight = 1'b1; nxt.stale = 1'b0;
    end else if (rsp) begin
      nxt.inflight = 1'b0;
      if (cur.stale) begin
        nxt.stale = 1'b0; nxt.issuing = 1'b1;
      end else begin
        nxt.out = 1'b1; nxt.out_pc = cur.pc; nxt.out_inst = imem_rsp_data_i;
      end
    end else if (cur.out && ready_i_ifu) begin
      nxt.out = 1'b0; nxt.pc = cur.pc + 64'd4; nxt.issuing = 1'b1;
    end
    return nxt;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= M_RESET;
    else     m <= model_next(m);
  end

  always @(negedge clk) begin
    check("req_valid", imem_req_valid_o, m.issuing);
    check("req_addr", imem_req_addr_o, m.pc);
    check("valid", valid_o_ifu, m.out);
    check("fault", fetch_fault_o, m.halted);
    if (m.out || rst) begin
      check("out_pc", pc_o_ifu, m.out_pc);
      check("out_inst", inst_o_ifu, m.out_inst);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic rq_rdy, input logic rsp_v, input logic [31:0] rsp_d,
                       input logic dec_rdy, input logic rd_v, input logic [63:0] rd_pc);
    imem_req_ready_i = rq_rdy;
    imem_rsp_valid_i = rsp_v;
    imem_rsp_data_i  = rsp_d;
    ready_i_ifu      = dec_rdy;
    redirect_valid_i = rd_v;
    redirect_pc_i    = rd_pc;
    step();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req_valid"}, imem_req_valid_o, 1'b0);
    check({tag, "_req_addr"}, imem_req_addr_o, 64'h8000_0000);
    check({tag, "_valid"}, valid_o_ifu, 1'b0);
    check({tag, "_inst"}, inst_o_ifu, 32'h0);
    check({tag, "_pc"}, pc_o_ifu, 64'h0);
    check({tag, "_fault"}, fetch_fault_o, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    imem_req_ready_i = 1'b0; imem_rsp_valid_i = 1'b0; imem_rsp_data_i = '0;
    ready_i_ifu = 1'b0; redirect_valid_i = 1'b0; redirect_pc_i = '0;
    repeat (2) @(posedge clk);
    #2;
    check_reset_values("rst0");
    rst = 1'b0;
    check("idle_no_req", imem_req_valid_o, 1'b0);

    // Basic fetch with zero-wait memory and ready decode.
    drive(1, 0, 32'h0, 1, 0, 64'h0);
    check("first_req_valid", imem_req_valid_o, 1'b1);
    check("first_req_addr", imem_req_addr_o, 64'h8000_0000);
    drive(1, 0, 32'h0, 1, 0, 64'h0);
    drive(0, 1, 32'h0000_0013, 1, 0, 64'h0);
    check("first_valid", valid_o_ifu, 1'b1);
    check("first_pc", pc_o_ifu, 64'h8000_0000);
    check("first_inst", inst_o_ifu, 32'h0000_0013);
    drive(1, 0, 32'h0, 1, 0, 64'h0);
    check("second_req_addr", imem_req_addr_o, 64'h8000_0004);

    // Decode backpressure for 5 cycles.
    drive(1, 0, 32'h0, 0, 0, 64'h0);
    drive(0, 1, 32'h0000_0093, 0, 0, 64'h0);
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 32'h0, 0, 0, 64'h0);
      check("hold_valid", valid_o_ifu, 1'b1);
      check("hold_pc", pc_o_ifu, 64'h8000_0004);
      check("hold_inst", inst_o_ifu, 32'h0000_0093);
      check("hold_no_req", imem_req_valid_o, 1'b0);
    end
    drive(1, 0, 32'h0, 1, 0, 64'h0);
    check("after_hold_addr", imem_req_addr_o, 64'h8000_0008);

    // Redirect in WAIT; the stale response must be discarded.
    drive(1, 0, 32'h0, 1, 0, 64'h0);
    drive(0, 0, 32'h0, 1, 1, 64'h8000_0100);
    check("wait_redir_no_req", imem_req_valid_o, 1'b0);
    drive(0, 1, 32'hDEAD_BEEF, 1, 0, 64'h0);
    check("stale_not_valid", valid_o_ifu, 1'b0);
    check("redir_req_valid", imem_req_valid_o, 1'b1);
    check("redir_req_addr", imem_req_addr_o, 64'h8000_0100);
    drive(1, 0, 32'h0, 1, 0, 64'h0);
    drive(0, 1, 32'h0010_0093, 0, 0, 64'h0);
    check("redir_pc", pc_o_ifu, 64'h8000_0100);
    check("redir_inst", inst_o_ifu, 32'h0010_0093);

    // Redirect in OUT with a same-cycle consume: target wins over PC+4.
    drive(0, 0, 32'h0, 1, 1, 64'h8000_0200);
    check("out_redir_valid", valid_o_ifu, 1'b0);
    check("out_redir_addr", imem_req_addr_o, 64'h8000_0200);
    // Redirect in REQ, not accepted, then accepted in the same cycle.
    drive(0, 0, 32'h0, 1, 1, 64'h8000_0300);
    check("req_redir_addr", imem_req_addr_o, 64'h8000_0300);
    drive(1, 0, 32'h0, 1, 1, 64'h8000_0400);
    check("acc_redir_no_req", imem_req_valid_o, 1'b0);
    drive(0, 1, 32'hBAD0_0000, 1, 0, 64'h0);
    check("acc_redir_addr", imem_req_addr_o, 64'h8000_0400);
    // Redirect in WAIT coinciding with the response.
    drive(1, 0, 32'h0, 1, 0, 64'h0);
    drive(0, 1, 32'hDEAD_0001, 1, 1, 64'h8000_0500);
    check("coincide_valid", valid_o_ifu, 1'b0);
    check("coincide_addr", imem_req_addr_o, 64'h8000_0500);

    // Misaligned redirect halts the stage until reset.
    drive(1, 0, 32'h0, 1, 0, 64'h0);
    drive(0, 1, 32'h0000_0013, 0, 0, 64'h0);
    drive(0, 0, 32'h0, 0, 1, 64'h8000_0102);
    check("halt_fault", fetch_fault_o, 1'b1);
    check("halt_valid", valid_o_ifu, 1'b0);
    check("halt_no_req", imem_req_valid_o, 1'b0);
    check("halt_pc_kept", imem_req_addr_o, 64'h8000_0500);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 32'h1111_1111, 1, 1, 64'h8000_0600);
      check("halt_stays", imem_req_valid_o, 1'b0);
    end

    // Reset out of HALT, then reset again in WAIT with a response around it.
    rst = 1'b1;
    drive(1, 0, 32'h0, 1, 0, 64'h0);
    rst = 1'b0;
    drive(1, 0, 32'h0, 1, 0, 64'h0);
    drive(1, 0, 32'h0, 1, 0, 64'h0);
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i  = 32'hFFFF_FFFF;
    rst = 1'b1;
    #1;
    check_reset_values("rst_wait");
    step();
    rst = 1'b0;
    imem_req_ready_i = 1'b0;
    step();
    check("post_rst_req_valid", imem_req_valid_o, 1'b1);
    check("post_rst_req_addr", imem_req_addr_o, 64'h8000_0000);
    check("post_rst_valid", valid_o_ifu, 1'b0);
    drive(0, 1, 32'h0000_0077, 1, 0, 64'h0);
    check("stray_rsp_ignored", valid_o_ifu, 1'b0);
    drive(1, 0, 32'h0, 1, 0, 64'h0);
    drive(0, 1, 32'h0000_0033, 1, 0, 64'h0);
    check("post_rst_pc", pc_o_ifu, 64'h8000_0000);
    check("post_rst_inst", inst_o_ifu, 32'h0000_0033);
    drive(0, 0, 32'h0, 1, 0, 64'h0);
    check("post_rst_next_addr", imem_req_addr_o, 64'h8000_0004);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ifu.md
# ifu

Instruction fetch stage of the single-issue RV64 core, directly upstream of the decode stage. Holds the architectural fetch PC, issues one 32-bit instruction fetch at a time on a valid/ready request channel to instruction memory, captures the response, and presents `{pc, inst}` to decode with a valid/ready handshake. Redirects (taken branch, jal/jalr) from execute flush in-flight work and restart fetch at the target.

## Interface
- `RESET_PC`, 64'h0000_0000_8000_0000: first fetch address after reset.
- `clk` in 1: core clock.
- `rst` in 1: asynchronous, active-high reset (`RstEnable` = 1'b1).
- `imem_req_valid_o` out 1: fetch request valid.
- `imem_req_ready_i` in 1: memory accepts request.
- `imem_req_addr_o` out 64: fetch address, always the current PC.
- `imem_rsp_valid_i` in 1: response valid (single cycle, no backpressure).
- `imem_rsp_data_i` in 32: fetched instruction.
- `inst_o_ifu` out 32: instruction to decode.
- `pc_o_ifu` out 64: PC of `inst_o_ifu`.
- `valid_o_ifu` out 1: `{pc, inst}` valid.
- `ready_i_ifu` in 1: decode consumes this cycle.
- `redirect_valid_i` in 1: restart fetch.
- `redirect_pc_i` in 64: restart target.
- `fetch_fault_o` out 1: sticky misaligned-redirect fault.

## Operation
- States: IDLE, REQ, WAIT, OUT, HALT.
- IDLE: reset state; PC = `RESET_PC`; next cycle -> REQ unconditionally.
- REQ: `imem_req_valid_o`=1, addr=PC. On `imem_req_ready_i` -> WAIT.
- WAIT: on `imem_rsp_valid_i` capture data into inst buffer, `pc_o_ifu` = PC -> OUT.
- OUT: `valid_o_ifu`=1. On `ready_i_ifu`: PC <= PC + 4 (64-bit wrap, no carry out), -> REQ.
- HALT: all valid outputs 0, `fetch_fault_o`=1; exit only by reset.
- Redirect (priority over every other event, any state but IDLE/HALT):
  - `redirect_pc_i[1:0]` != 0 -> HALT, PC unchanged.
  - REQ, request not accepted same cycle: PC <= target, stay REQ (address may change only here).
  - REQ, accepted same cycle, or WAIT: PC <= target, set `drop`, -> WAIT; response arriving in WAIT with `drop`=1 is discarded, `drop` cleared, -> REQ. Redirect in WAIT coinciding with the response: discard it, -> REQ.
  - OUT: discard buffer, `valid_o_ifu` drops next cycle even if `ready_i_ifu`=1 same cycle (the consume happens, PC takes target not PC+4), -> REQ.
- `imem_rsp_valid_i` outside WAIT is ignored.
- Only one outstanding request ever.

## Timing
- Reset values: `imem_req_valid_o`=0, `imem_req_addr_o`=`RESET_PC`, `valid_o_ifu`=0, `inst_o_ifu`=0, `pc_o_ifu`=0, `fetch_fault_o`=0, `drop`=0, state IDLE. Reset mid-request abandons it; later responses land in IDLE/REQ and are ignored.
- Request accepted at edge T; response earliest in cycle T+1; `valid_o_ifu` high from the cycle after the response.
- Best case: 3 cycles per instruction (REQ, WAIT, OUT) with zero-wait memory and ready decode.
- Redirect takes effect at the next edge; first request to the target is issued the following cycle (REQ) or after the stale response drains (WAIT).
- Outputs registered except `imem_req_valid_o` / `imem_req_addr_o` (decoded from state and PC register).

## Structure
- Shared define file: `RESET_PC` default, state encodings, `InstBus` (32), `InstAddrBus` (64), `RstEnable`.
- One sub-module natural: `ifu_pc` — PC register plus next-PC mux (hold / +4 / redirect target), async reset to `RESET_PC`.

## Test plan
- Reset release, memory ready=1, rsp 1 cycle later with 32'h0000_0013 -> request at 0x8000_0000, `valid_o_ifu`=1 with pc 0x8000_0000 inst 0x13; next request at 0x8000_0004.
- Decode holds `ready_i_ifu`=0 for 5 cycles -> `valid_o_ifu`, inst, pc stable; no new request issued.
- Redirect to 0x8000_0100 while in WAIT; stale response returns 0xDEAD_BEEF -> discarded, next request addr 0x8000_0100, only its instruction reaches decode.
- Redirect to 0x8000_0200 in OUT with `ready_i_ifu`=1 same cycle -> `valid_o_ifu` low next cycle, next request addr 0x8000_0200 (not pc+4).
- Redirect to 0x8000_0102 -> HALT, `fetch_fault_o`=1, no further requests until `rst`.
- Assert `rst` in WAIT, response arrives during reset and one cycle after -> outputs at reset values, first post-reset fetch at 0x8000_0000, stray response ignored.
